elevator_call_scheduler: RTL

//  Issuing side of the floor_request interface of the elevator controller FSM.
//  - Latches hall/car call buttons into a pending-call register.
//  - Picks the next target with a SCAN (keep-direction) policy and drives floor_request.
//  - Watches controller state/door_open to detect arrival, clear the served call and dwell.
//  - Sits between the button panel and the controller; one instance per car.

---
 rtl/elevator_call_scheduler.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - SCAN call scheduler driving floor_request to the elevator controller
//
// Purpose: latches hall/car call buttons into a pending bitmap, picks the next
// target with a keep-direction SCAN policy, watches the controller for arrival,
// clears the served call and dwells before selecting again. One per car.
//
// Ports:
//   i_clk             clock, rising edge
//   i_rst             asynchronous active-high reset
//   i_call_btn        raw button levels, bit i = floor i (rising edge = new call)
//   i_emergency_stop  freezes the FSM while high; calls are still captured
//   i_ctrl_state      controller state: 00 idle, 01 up, 10 down, 11 open
//   i_current_floor   controller current floor
//   i_door_open       controller door flag
//   o_floor_request   registered target floor to the controller
//   o_pending         registered pending-call bitmap
//   o_dir_up          registered SCAN direction, 1 = up
//   o_svc_pulse       one-cycle pulse when a call is cleared
//   o_service_count   saturating count of services (only with SCHED_STATS_EN)
//
// Build option: define SCHED_STATS_EN to add o_service_count.

module elevator_call_scheduler #(
  parameter int NUM_FLOORS       = 4,
  parameter int FLOOR_W          = 2,
  parameter int REQ_W            = 4,
  parameter int HOME_FLOOR       = 1,
  parameter int DWELL_CYCLES     = 8,
  parameter int DISPATCH_TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_FLOORS-1:0] i_call_btn,
  input  logic                  i_emergency_stop,
  input  logic [1:0]            i_ctrl_state,
  input  logic [FLOOR_W-1:0]    i_current_floor,
  input  logic                  i_door_open,
  output logic [REQ_W-1:0]      o_floor_request,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_dir_up,
  output logic                  o_svc_pulse
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]           o_service_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_DISPATCH, S_TRAVEL, S_HOLD} state_t;

  localparam int TMAX    = (DWELL_CYCLES > DISPATCH_TIMEOUT) ? DWELL_CYCLES : DISPATCH_TIMEOUT;
  localparam int TIMER_W = $clog2(TMAX + 1);
  localparam logic [TIMER_W-1:0] DWELL_LAST = TIMER_W'(DWELL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DISP_LAST  = TIMER_W'(DISPATCH_TIMEOUT - 1);

  state_t                r_state;
  logic [TIMER_W-1:0]    r_timer;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] r_btn_q;
  logic                  r_door_q;
  logic                  r_estop_q;
  logic                  r_dir_up;
  logic                  r_svc;
  logic [REQ_W-1:0]      r_floor_req;

  logic                  w_cf_ok;
  logic                  w_run;
  logic                  w_door_rise;
  logic                  w_cf_pending;
  logic                  w_above_found;
  logic                  w_below_found;
  logic [FLOOR_W-1:0]    w_above;
  logic [FLOOR_W-1:0]    w_below;
  logic                  w_clr_sel;
  logic                  w_clr_trav;
  logic [NUM_FLOORS-1:0] w_btn_rise;
  logic [NUM_FLOORS-1:0] w_clr_mask;
  logic [REQ_W-1:0]      w_cf_req;

  assign w_cf_ok      = int'(i_current_floor) < NUM_FLOORS;
  // The cycle emergency_stop drops is spent returning to S_IDLE, so it is not a run cycle.
  assign w_run        = !i_emergency_stop && !r_estop_q;
  assign w_door_rise  = i_door_open && !r_door_q;
  assign w_cf_pending = w_cf_ok && r_pending[i_current_floor];
  assign w_cf_req     = REQ_W'(i_current_floor);
  assign w_btn_rise   = i_call_btn & ~r_btn_q;

  // Nearest pending call strictly above / below the current floor.
  always_comb begin
    w_above_found = 1'b0;
    w_above       = '0;
    w_below_found = 1'b0;
    w_below       = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (r_pending[i] && i > int'(i_current_floor)) begin
        w_above_found = 1'b1;
        w_above       = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (r_pending[i] && i < int'(i_current_floor)) begin
        w_below_found = 1'b1;
        w_below       = FLOOR_W'(i);
      end
    end
  end

  assign w_clr_sel  = w_run && (r_state == S_SELECT) && w_cf_pending;
  assign w_clr_trav = w_run && w_cf_ok && (r_state == S_TRAVEL) && w_door_rise &&
                      (i_ctrl_state == 2'b11);
  assign w_clr_mask = (w_clr_sel || w_clr_trav) ? (NUM_FLOORS'(1) << i_current_floor) : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_pending   <= '0;
      r_btn_q     <= '0;
      r_door_q    <= 1'b0;
      r_estop_q   <= 1'b0;
      r_dir_up    <= 1'b1;
      r_svc       <= 1'b0;
      r_floor_req <= REQ_W'(HOME_FLOOR);
    end else begin
      r_btn_q   <= i_call_btn;
      r_door_q  <= i_door_open;
      r_estop_q <= i_emergency_stop;
      // A clear in the same cycle as a new edge on that floor wins.
      r_pending <= (r_pending | w_btn_rise) & ~w_clr_mask;
      r_svc     <= w_clr_sel || w_clr_trav;
      if (!i_emergency_stop) begin
        if (r_estop_q || !w_cf_ok) begin
          r_state <= S_IDLE;
        end else begin
          case (r_state)
            S_IDLE: begin
              r_floor_req <= w_cf_req;
              if (|r_pending) r_state <= S_SELECT;
            end
            S_SELECT: begin
              r_timer <= '0;
              if (w_cf_pending) begin
                r_floor_req <= w_cf_req;
                r_state     <= S_HOLD;
              end else if (w_above_found && (r_dir_up || !w_below_found)) begin
                r_floor_req <= REQ_W'(w_above);
                r_dir_up    <= 1'b1;
                r_state     <= S_DISPATCH;
              end else if (w_below_found) begin
                r_floor_req <= REQ_W'(w_below);
                r_dir_up    <= 1'b0;
                r_state     <= S_DISPATCH;
              end else begin
                r_state <= S_IDLE;
              end
            end
            S_DISPATCH: begin
              // Only cycles with the controller sitting idle count toward the timeout.
              if (i_ctrl_state == 2'b01 || i_ctrl_state == 2'b10) begin
                r_state <= S_TRAVEL;
              end else if (i_ctrl_state == 2'b00) begin
                if (r_timer == DISP_LAST) r_state <= S_IDLE;
                else r_timer <= r_timer + 1'b1;
              end
            end
            S_TRAVEL: begin
              if (w_clr_trav) begin
                r_floor_req <= w_cf_req;
                r_timer     <= '0;
                r_state     <= S_HOLD;
              end
            end
            S_HOLD: begin
              r_floor_req <= w_cf_req;
              if (r_timer == DWELL_LAST) r_state <= S_IDLE;
              else r_timer <= r_timer + 1'b1;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign o_floor_request = r_floor_req;
  assign o_pending       = r_pending;
  assign o_dir_up        = r_dir_up;
  assign o_svc_pulse     = r_svc;

`ifdef SCHED_STATS_EN
  logic [15:0] r_service_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_service_count <= '0;
    else if (r_svc && r_service_count != 16'hFFFF) r_service_count <= r_service_count + 16'd1;
  end

  assign o_service_count = r_service_count;
`endif

endmodule
